// File: rtl/df_multiplier_c2.sv
// df_multiplier_c2
//   Multiplies an unsigned 8-bit sample by an 8-bit fractional coefficient
//   c/256. Five coefficient bits are fixed and three come from a code:
//   c = {0, coef[2], 0, coef[1], 1, coef[0], 1, 0}.
//   The product comes from a combinational shift-and-add reduction chain.
//   Only the upper byte of the product is registered.
//
// Ports
//   clk   in   1  system clock, rising edge
//   rst   in   1  synchronous active-high reset, clears out
//   coef  in   3  coefficient select code
//   data  in   8  unsigned input sample
//   out   out  8  registered floor(data * c / 256)
module df_multiplier_c2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] coef,
  input  logic [7:0] data,
  output logic [7:0] out
);

  // Reduction chain. These arrays keep these names so simulation can probe them.
  logic [15:0] stage1 [0:4];
  logic [15:0] stage2 [0:3];
  logic [15:0] stage3 [0:2];
  logic [15:0] stage4 [0:1];
  logic [15:0] product;

  logic [7:0] out_d;
  logic [7:0] out_q;

  // Truncating scale back to the output width: keep product[15:8].
  // The largest product is 255 * 94, so bit 15 is always 0 and nothing is lost.
  function automatic logic [7:0] trunc_hi(input logic [15:0] p);
    logic [15:0] shifted;
    shifted  = p >> 8;
    trunc_hi = shifted[7:0];
  endfunction

  // Stage 1: partial products. The 8-bit sample is zero-extended to 16 bits before shifting.
  always_comb begin
    logic [15:0] d16;
    d16       = {8'h00, data};
    stage1[0] = d16 << 1;
    stage1[1] = coef[0] ? (d16 << 2) : 16'h0000;
    stage1[2] = d16 << 3;
    stage1[3] = coef[1] ? (d16 << 4) : 16'h0000;
    stage1[4] = coef[2] ? (d16 << 6) : 16'h0000;
  end

  // Stages 2-4: each stage adds its first two entries and passes the rest through.
  always_comb begin
    stage2[0] = stage1[0] + stage1[1];
    stage2[1] = stage1[2];
    stage2[2] = stage1[3];
    stage2[3] = stage1[4];

    stage3[0] = stage2[0] + stage2[1];
    stage3[1] = stage2[2];
    stage3[2] = stage2[3];

    stage4[0] = stage3[0] + stage3[1];
    stage4[1] = stage3[2];

    product   = stage4[0] + stage4[1];
  end

  // Output register boundary
  always_comb begin
    out_d = trunc_hi(product);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 8'h00;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_df_multiplier_c2.sv
// tb_df_multiplier_c2
//   Self-checking bench for df_multiplier_c2. A behavioural model computes
//   floor(data * c / 256). The model takes c from the table of effective
//   coefficient values. It is not built from the partial-product tree.
module tb_df_multiplier_c2;

  logic       clk;
  logic       rst;
  logic [2:0] coef;
  logic [7:0] data;
  logic [7:0] out;

  int pass_cnt;
  int total_cnt;

  df_multiplier_c2 dut (
    .clk  (clk),
    .rst  (rst),
    .coef (coef),
    .data (data),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int coef_value(input logic [2:0] k);
    case (k)
      3'd0: return 10;
      3'd1: return 14;
      3'd2: return 26;
      3'd3: return 30;
      3'd4: return 74;
      3'd5: return 78;
      3'd6: return 90;
      default: return 94;
    endcase
  endfunction

  function automatic logic [7:0] ref_out(input logic [7:0] d, input logic [2:0] k);
    int p;
    p = int'(d) * coef_value(k);
    return 8'(p / 256);
  endfunction

  // Set inputs at a negedge, then sample out 1 time unit after the next posedge.
  task automatic apply_and_clock(input logic r, input logic [7:0] d, input logic [2:0] k);
    @(negedge clk);
    rst  = r;
    data = d;
    coef = k;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_and_clock(1'b1, 8'hFF, 3'd7);
    apply_and_clock(1'b1, 8'hFF, 3'd7);
    total_cnt++;
    if (out !== 8'd0) $display("FAIL reset_hold out=%0d expected=%0d", out, 0);
    else pass_cnt++;
    apply_and_clock(1'b0, 8'hFF, 3'd7);
    total_cnt++;
    if (out !== 8'd93) $display("FAIL reset_release out=%0d expected=%0d", out, 93);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    int exp_tab[8] = '{9, 13, 25, 29, 73, 77, 89, 93};
    for (int k = 0; k < 8; k++) begin
      apply_and_clock(1'b0, 8'hFF, 3'(k));
      total_cnt++;
      if (out !== 8'(exp_tab[k]))
        $display("FAIL sweep coef=%0d out=%0d expected=%0d", k, out, exp_tab[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 8; k += 3) begin
      apply_and_clock(1'b0, 8'h00, 3'(k));
      total_cnt++;
      if (out !== 8'd0) $display("FAIL zero_data coef=%0d out=%0d expected=0", k, out);
      else pass_cnt++;
    end
    apply_and_clock(1'b0, 8'h01, 3'd7);
    total_cnt++;
    if (out !== 8'd0) $display("FAIL trunc_one out=%0d expected=0", out);
    else pass_cnt++;
  endtask

  task automatic test_midrange();
    apply_and_clock(1'b0, 8'h80, 3'd5);
    total_cnt++;
    if (out !== 8'd39) $display("FAIL mid_80_5 out=%0d expected=39", out);
    else pass_cnt++;
    apply_and_clock(1'b0, 8'h64, 3'd2);
    total_cnt++;
    if (out !== 8'd10) $display("FAIL mid_64_2 out=%0d expected=10", out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [2:0] k;
    logic [7:0] exp_v;
    d = 8'h00;
    k = 3'd0;
    for (int i = 0; i < 64; i++) begin
      d = 8'($urandom_range(0, 255));
      k = 3'($urandom_range(0, 7));
      apply_and_clock(1'b0, d, k);
      exp_v = ref_out(d, k);
      total_cnt++;
      if (out !== exp_v) $display("FAIL b2b d=%0d coef=%0d out=%0d expected=%0d", d, k, out, exp_v);
      else pass_cnt++;
    end
    // With the inputs held constant, out must not move.
    exp_v = ref_out(d, k);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (out !== exp_v) $display("FAIL hold cycle=%0d out=%0d expected=%0d", i, out, exp_v);
      else pass_cnt++;
    end
    // Changing the inputs between edges must not change out before the next edge.
    @(negedge clk);
    data = ~d;
    coef = ~k;
    #2;
    total_cnt++;
    if (out !== exp_v) $display("FAIL between_edges out=%0d expected=%0d", out, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    apply_and_clock(1'b0, 8'hC8, 3'd6);
    total_cnt++;
    if (out !== ref_out(8'hC8, 3'd6))
      $display("FAIL midstream_pre out=%0d expected=%0d", out, ref_out(8'hC8, 3'd6));
    else pass_cnt++;
    apply_and_clock(1'b1, 8'hFF, 3'd7);
    total_cnt++;
    if (out !== 8'd0) $display("FAIL midstream_reset out=%0d expected=0", out);
    else pass_cnt++;
    apply_and_clock(1'b0, 8'hAA, 3'd3);
    total_cnt++;
    if (out !== ref_out(8'hAA, 3'd3))
      $display("FAIL midstream_post out=%0d expected=%0d", out, ref_out(8'hAA, 3'd3));
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    int errs;
    logic [15:0] probe;
    logic [15:0] exp_p;
    logic [7:0]  exp_v;
    errs = 0;
    for (int d = 0; d < 256; d++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        rst  = 1'b0;
        data = 8'(d);
        coef = 3'(k);
        #1;
        probe = dut.stage4[0] + dut.stage4[1];
        exp_p = 16'(d * coef_value(3'(k)));
        total_cnt++;
        if (probe !== exp_p) begin
          errs++;
          if (errs < 10) $display("FAIL probe d=%0d coef=%0d sum=%0d expected=%0d", d, k, probe, exp_p);
        end else pass_cnt++;
        @(posedge clk);
        #1;
        exp_v = ref_out(8'(d), 3'(k));
        total_cnt++;
        if (out !== exp_v) begin
          errs++;
          if (errs < 10) $display("FAIL exhaustive d=%0d coef=%0d out=%0d expected=%0d", d, k, out, exp_v);
        end else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst  = 1'b1;
    data = 8'h00;
    coef = 3'd0;
    test_reset();
    test_sweep();
    test_zero();
    test_midrange();
    test_back_to_back();
    test_reset_midstream();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/df_multiplier_c2.md
# df_multiplier_c2

Constant-structure coefficient multiplier for the digital filter datapath. It multiplies an unsigned 8-bit sample by an 8-bit fractional coefficient. Five of the coefficient's bits are fixed and three are selected by a 3-bit coefficient code. The product is formed by a shift-and-add reduction tree. The upper byte of the 16-bit product is registered and driven to the filter accumulator.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- coef  input  3  coefficient select code.
- data  input  8  unsigned input sample.
- out  output  8  registered result: upper byte of data × c.

## Operation
- Effective coefficient c (8 bits, unsigned, value c/256) is {0, coef[2], 0, coef[1], 1, coef[0], 1, 0}.
  - c[7] = 0, c[6] = coef[2], c[5] = 0, c[4] = coef[1], c[3] = 1, c[2] = coef[0], c[1] = 1, c[0] = 0.
  - Values for coef = 0 through 7: 10, 14, 26, 30, 74, 78, 90, 94.
- Stage 1 has five 16-bit partial products, each zero-extended before shifting:
  - stage1[0] = data<<1
  - stage1[1] = coef[0] ? data<<2 : 0
  - stage1[2] = data<<3
  - stage1[3] = coef[1] ? data<<4 : 0
  - stage1[4] = coef[2] ? data<<6 : 0
- Reduction runs as a chain of 16-bit stages. Each stage adds the first two entries of the previous stage and passes the remaining entries through unchanged.
  - stage2 (4 entries): stage2[0] = stage1[0] + stage1[1]; stage2[1..3] = stage1[2..4].
  - stage3 (3 entries): stage3[0] = stage2[0] + stage2[1]; stage3[1..2] = stage2[2..3].
  - stage4 (2 entries): stage4[0] = stage3[0] + stage3[1]; stage4[1] = stage3[2].
  - product = stage4[0] + stage4[1].
- The arrays stage1..stage4 are named internal signals so they can be probed in simulation.
- Arithmetic rules:
  - All arithmetic is unsigned, 16 bits wide, with no overflow possible (maximum product 255 × 94 = 23970).
  - The result is truncated, not rounded: out = product[15:8] = floor(data × c / 256).
  - Maximum output is 93; out[7] is always 0.
- The reduction tree is fully combinational. Only out is registered.

## Timing
- Reset:
  - On a rising edge of clk with rst = 1, out becomes 8'h00.
  - rst has priority over new data.
  - Asserting reset mid-stream discards the pending result.
- Normal operation: on each rising edge with rst = 0, out takes floor(data × c / 256) computed from the data and coef values present before that edge.
- Latency is 1 cycle. Throughput is one result per cycle. There is no handshake or valid signal.
- out holds its value between edges. Changes on coef or data between edges have no effect on out until the next edge.
- First edge after reset deasserts: out reflects the inputs sampled at that edge.

## Test plan
- Reset: hold rst = 1 for 2 cycles with data = 8'hFF and coef = 7 -> out = 0. Release rst -> out = 93 one cycle later.
- Coefficient sweep at full scale: data = 8'hFF, coef stepped 0 through 7, one value per cycle -> out = 9, 13, 25, 29, 73, 77, 89, 93, each appearing one cycle after its coef is applied.
- Zero input: data = 0, any coef -> out = 0. data = 1, coef = 7 -> out = 0 (truncation, 94/256).
- Mid-range value: data = 8'h80, coef = 5 -> out = 39 (128 × 78 = 9984, >> 8 = 39). data = 8'h64, coef = 2 -> out = 10 (100 × 26 = 2600, >> 8 = 10).
- Pipeline and hold: change inputs every cycle using random data and coef -> each out equals floor(data × c / 256) of the previous cycle's inputs. Inputs held constant -> out remains stable.
- Exhaustive check: all 2048 combinations of (data, coef), compared against a reference model floor(data × c / 256) with 1-cycle alignment -> zero mismatches. Probe stage4[0] + stage4[1] == data × c each cycle.
